new_alu: RTL and testbench
==========================

# new_alu

Registered, parameterised arithmetic/logic unit with 12 opcodes: shifts, signed add/subtract/divide, comparisons, bit-select, and sign-magnitude ↔ two's-complement (U2) conversion. Operands are combinationally evaluated and captured on the clock edge into a result register and a 4-bit status register. It is a leaf datapath block, driven by a controller that supplies an opcode and two operands per cycle.

## Interface
- N, default 4: opcode width (≥4).
- M, default 8: operand width.
- K, default 8: result width (K ≥ M).
- i_clk  in  1  rising-edge clock.
- i_reset  in  1  synchronous, active-high reset.
- i_op  in  N  opcode.
- i_arg_A  in  M  operand A.
- i_arg_B  in  M  operand B.
- o_result  out  K  registered result.
- o_status  out  4  registered flags: [0] ZERO, [1] NEGATIVE, [2] OVERFLOW, [3] ERROR.

## Operation
- Operands are U2 signed unless stated otherwise. ~X is the bitwise NOT at M bits. Signed results are sign-extended to K; boolean and logical results are zero-extended.
- 0: A >> ~B, logical shift; ~B is read unsigned; shift ≥ M gives 0.
- 1: A + ~B, signed; OVERFLOW if the true sum does not fit in K signed bits.
- 2: A / B, signed, truncates toward zero; B=0 → ERROR; overflow (e.g. −2^(M−1)/−1) → OVERFLOW.
- 3: A as sign-magnitude → U2; 0x80 (negative zero) → 0.
- 4: A − 2·B, computed at M+2 bits; OVERFLOW if the result does not fit in K signed bits.
- 5: A < B, signed compare; result 1 or 0.
- 6: bit B of (A+B) mod 2^M, giving 1 or 0; B read unsigned; B ≥ M → ERROR.
- 7: A as U2 → sign-magnitude; A = −2^(M−1) → ERROR.
- 8: ~A >> B, logical; B read unsigned; shift ≥ M gives 0.
- 9: ~A ≥ B, signed; result 1 or 0.
- 10: ~A / B, signed, rules as op 2.
- 11: ~|B|; B = −2^(M−1) → ERROR.
- 12–15: ERROR.
- ERROR: o_result = 0, status = 4'b1000, with no other flag set.
- Otherwise: ZERO = (result == 0), NEGATIVE = result[K−1], OVERFLOW per the op. On OVERFLOW the result holds the truncated low K bits.

## Timing
- Single-cycle latency. Inputs sampled at the rising i_clk edge; outputs are valid after that edge and hold until the next edge.
- i_reset high at an edge: o_result = 0 and o_status = 0. Reset has priority over any opcode.
- Reset released: the first operation result appears at the first edge with i_reset low.
- No handshake. A new opcode and operands are accepted every cycle, and back-to-back operations are independent.
- Outputs are 0 from the first reset edge. Outputs before any reset are undefined.

## Structure
- Package new_alu_pkg holds:
  - the opcode enum (OP_SHR_NB … OP_NABS_B, values 0–11);
  - the status bit index constants ST_ZERO/ST_NEG/ST_OVF/ST_ERR.
- Sub-module alu_sdiv: combinational signed M-bit divider with a divide-by-zero flag, shared by ops 2 and 10.
- All other logic sits in one combinational case block feeding the output registers.

## Test plan
- Op 0, A=0xCC, B=0xFE → result 0x66, status 0000. Op 1, A=0x02, B=0xFC → 0x05, status 0000.
- Op 2, A=13, B=3 → 4. Op 2, B=0 → result 0, status 1000. Op 10, A=0xF8, B=1 → 7.
- Op 3, A=0x8A → 0xF6, NEGATIVE set. Op 7, A=0xF9 → 0x87. Op 7, A=0x80 → ERROR.
- Op 4, A=3, B=1 → 1. Op 5, A=6, B=3 → 0, ZERO set. Op 6, A=3, B=2 → 1. Op 9, A=0xFC, B=1 → 1.
- Op 8, A=0xFC, B=0x0C → 0, ZERO set. Op 11, B=0x55 → 0xAA. Op 12 → ERROR.
- Reset: issue op 1 with i_reset=1 → outputs 0 at that edge. Deassert → the op 1 result appears on the next edge.

Source files
------------

// File: rtl/new_alu_pkg.sv
// Shared opcode encoding and status flag positions for the new_alu datapath.
package new_alu_pkg;

   typedef enum logic [3:0] {
      OP_SHR_NB  = 4'd0,
      OP_ADD_NB  = 4'd1,
      OP_DIV     = 4'd2,
      OP_SM2U2   = 4'd3,
      OP_SUB_2B  = 4'd4,
      OP_LT      = 4'd5,
      OP_BIT     = 4'd6,
      OP_U22SM   = 4'd7,
      OP_NA_SHR  = 4'd8,
      OP_NA_GE   = 4'd9,
      OP_NA_DIV  = 4'd10,
      OP_NABS_B  = 4'd11
   } alu_op_e;

   localparam int ST_ZERO = 0;
   localparam int ST_NEG  = 1;
   localparam int ST_OVF  = 2;
   localparam int ST_ERR  = 3;

endpackage

// File: rtl/new_alu_sdiv.sv
// Combinational signed M-bit divider, truncating toward zero.
// The quotient is M+1 bits wide so that -2^(M-1) / -1 is represented exactly.
module alu_sdiv #(
   parameter int M = 8
) (
   input  logic [M-1:0] dividend,
   input  logic [M-1:0] divisor,
   output logic [M:0]   quotient,
   output logic         div_zero
);

   logic [M-1:0] mag_a, mag_b, safe_b, q_mag;
   logic         q_neg;

   // Magnitudes are unsigned M-bit, so |-2^(M-1)| still fits.
   assign mag_a    = dividend[M-1] ? (M'(0) - dividend) : dividend;
   assign mag_b    = divisor[M-1]  ? (M'(0) - divisor)  : divisor;
   assign div_zero = (divisor == '0);
   assign safe_b   = div_zero ? M'(1) : mag_b;
   assign q_mag    = mag_a / safe_b;
   assign q_neg    = dividend[M-1] ^ divisor[M-1];
   assign quotient = q_neg ? ((M+1)'(0) - {1'b0, q_mag}) : {1'b0, q_mag};

endmodule

// File: rtl/new_alu.sv
// Registered 12-opcode ALU: one combinational evaluation per cycle captured
// into a K-bit result register and a 4-bit status register.
module new_alu
   import new_alu_pkg::*;
#(
   parameter int N = 4,
   parameter int M = 8,
   parameter int K = 8
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic [N-1:0] i_op,
   input  logic [M-1:0] i_arg_A,
   input  logic [M-1:0] i_arg_B,
   output logic [K-1:0] o_result,
   output logic [3:0]   o_status
);

   // Wide enough to hold every exact intermediate (A - 2B needs M+2 bits).
   localparam int XW = K + 2;

   function automatic logic fits_k(input logic signed [XW-1:0] v);
      return v == XW'($signed(v[K-1:0]));
   endfunction

   alu_op_e             op_e;
   logic [M-1:0]        na, nb, sum_ab, div_a, smag, b_abs, nabs_b, shr0, shr8;
   logic signed [M-1:0] a_s, b_s, na_s, nb_s, sm2u2;
   logic signed [XW-1:0] add_w, sub_w, div_w;
   logic [M:0]          quot;
   logic                div_zero, bit6;
   logic [K-1:0]        res;
   logic                ovf, err;
   logic [3:0]          status_n;

   assign op_e   = alu_op_e'(i_op[3:0]);
   assign na     = ~i_arg_A;
   assign nb     = ~i_arg_B;
   assign a_s    = i_arg_A;
   assign b_s    = i_arg_B;
   assign na_s   = na;
   assign nb_s   = nb;

   // Verilog shifts by >= width already yield zero, matching the op rules.
   assign shr0   = i_arg_A >> nb;
   assign shr8   = na >> i_arg_B;
   assign sum_ab = i_arg_A + i_arg_B;
   assign bit6   = |(sum_ab & (M'(1) << i_arg_B));

   assign sm2u2  = i_arg_A[M-1] ? (M'(0) - {1'b0, i_arg_A[M-2:0]})
                                : {1'b0, i_arg_A[M-2:0]};
   assign smag   = i_arg_A[M-1] ? ((M'(0) - i_arg_A) | {1'b1, {(M-1){1'b0}}})
                                : i_arg_A;
   assign b_abs  = i_arg_B[M-1] ? (M'(0) - i_arg_B) : i_arg_B;
   assign nabs_b = ~b_abs;

   assign add_w  = XW'(a_s) + XW'(nb_s);
   assign sub_w  = XW'(a_s) - (XW'(b_s) <<< 1);
   assign div_a  = (op_e == OP_NA_DIV) ? na : i_arg_A;
   assign div_w  = XW'($signed(quot));

   alu_sdiv #(.M(M)) u_sdiv (
      .dividend (div_a),
      .divisor  (i_arg_B),
      .quotient (quot),
      .div_zero (div_zero)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      res = '0;
      ovf = 1'b0;
      err = 1'b0;
      if (i_op > N'(11)) begin
         err = 1'b1;
      end else begin
         case (op_e)
            OP_SHR_NB: res = K'(shr0);
            OP_ADD_NB: begin
               res = add_w[K-1:0];
               ovf = !fits_k(add_w);
            end
            OP_DIV, OP_NA_DIV: begin
               err = div_zero;
               res = div_w[K-1:0];
               ovf = !fits_k(div_w);
            end
            OP_SM2U2:  res = K'(sm2u2);
            OP_SUB_2B: begin
               res = sub_w[K-1:0];
               ovf = !fits_k(sub_w);
            end
            OP_LT:     res = {{(K-1){1'b0}}, (a_s < b_s)};
            OP_BIT: begin
               err = (i_arg_B >= M'(M));
               res = {{(K-1){1'b0}}, bit6};
            end
            OP_U22SM: begin
               err = (i_arg_A == {1'b1, {(M-1){1'b0}}});
               res = K'(smag);
            end
            OP_NA_SHR: res = K'(shr8);
            OP_NA_GE:  res = {{(K-1){1'b0}}, (na_s >= b_s)};
            OP_NABS_B: begin
               err = (i_arg_B == {1'b1, {(M-1){1'b0}}});
               res = K'(nabs_b);
            end
            default:   err = 1'b1;
         endcase
      end

      status_n          = '0;
      status_n[ST_ZERO] = (res == '0);
      status_n[ST_NEG]  = res[K-1];
      status_n[ST_OVF]  = ovf;
      if (err) status_n = 4'b1000;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_result <= '0;
         o_status <= '0;
      end else begin
         o_result <= err ? '0 : res;
         o_status <= status_n;
      end
   end

endmodule

// File: tb/tb_new_alu.sv
// Self-checking bench for new_alu: directed spec vectors, reset behaviour,
// then randomized operations against an integer-arithmetic reference model.
module tb_new_alu;

   logic       i_clk;
   logic       i_reset;
   logic [3:0] i_op;
   logic [7:0] i_arg_A;
   logic [7:0] i_arg_B;
   logic [7:0] o_result;
   logic [3:0] o_status;

   int checks = 0;
   int errors = 0;

   new_alu #(.N(4), .M(8), .K(8)) dut (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_op     (i_op),
      .i_arg_A  (i_arg_A),
      .i_arg_B  (i_arg_B),
      .o_result (o_result),
      .o_status (o_status)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   function automatic int sx(input int u);
      return (u >= 128) ? u - 256 : u;
   endfunction

   // Reference model: plain integer arithmetic, returns {status, result}.
   function automatic logic [11:0] model(input int op, input int ua, input int ub);
      int  a, b, na, nb, r, v;
      bit  err, ovf;
      logic [7:0] r8;
      logic [3:0] st;
      a = sx(ua); b = sx(ub);
      na = sx(255 - ua); nb = sx(255 - ub);
      r = 0; err = 0; ovf = 0;
      case (op)
         0: r = ((255 - ub) >= 8) ? 0 : (ua >> (255 - ub));
         1: begin v = a + nb; ovf = (v < -128 || v > 127); r = v; end
         2: if (b == 0) err = 1; else begin v = a / b; ovf = (v < -128 || v > 127); r = v; end
         3: r = (ua >= 128) ? -(ua - 128) : ua;
         4: begin v = a - 2 * b; ovf = (v < -128 || v > 127); r = v; end
         5: r = (a < b) ? 1 : 0;
         6: if (ub >= 8) err = 1; else r = (((ua + ub) % 256) >> ub) & 1;
         7: if (ua == 128) err = 1; else r = (a < 0) ? 128 + (-a) : ua;
         8: r = (ub >= 8) ? 0 : ((255 - ua) >> ub);
         9: r = (na >= b) ? 1 : 0;
         10: if (b == 0) err = 1; else begin v = na / b; ovf = (v < -128 || v > 127); r = v; end
         11: if (ub == 128) err = 1; else r = 255 - ((b < 0) ? -b : b);
         default: err = 1;
      endcase
      r8 = r[7:0];
      if (err) begin
         r8 = 8'h00;
         st = 4'b1000;
      end else begin
         st = {1'b0, ovf, r8[7], (r8 == 8'h00)};
      end
      return {st, r8};
   endfunction

   task automatic check(input string tag, input logic [7:0] exp_r, input logic [3:0] exp_s);
      checks++;
      assert (o_result === exp_r) else begin
         errors++;
         $error("FAIL %s result: got %h expected %h", tag, o_result, exp_r);
      end
      checks++;
      assert (o_status === exp_s) else begin
         errors++;
         $error("FAIL %s status: got %b expected %b", tag, o_status, exp_s);
      end
   endtask

   // Drive one operation, let it be captured, sample 1 time unit after the edge.
   task automatic step(input logic rst, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      i_reset = rst; i_op = op; i_arg_A = a; i_arg_B = b;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      logic [11:0] exp;
      int op, ua, ub;
      bit rst;

      i_reset = 1'b1; i_op = '0; i_arg_A = '0; i_arg_B = '0;
      step(1, 4'd0, 8'h00, 8'h00);
      step(1, 4'd0, 8'h00, 8'h00);
      check("reset", 8'h00, 4'b0000);

      step(0, 4'd0,  8'hCC, 8'hFE); check("op0_shr_nb",   8'h66, 4'b0000);
      step(0, 4'd1,  8'h02, 8'hFC); check("op1_add_nb",   8'h05, 4'b0000);
      step(0, 4'd1,  8'h7F, 8'hFE); check("op1_ovf",      8'h80, 4'b0110);
      step(0, 4'd2,  8'h0D, 8'h03); check("op2_div",      8'h04, 4'b0000);
      step(0, 4'd2,  8'h0D, 8'h00); check("op2_div0",     8'h00, 4'b1000);
      step(0, 4'd2,  8'h80, 8'hFF); check("op2_ovf",      8'h80, 4'b0110);
      step(0, 4'd10, 8'hF8, 8'h01); check("op10_na_div",  8'h07, 4'b0000);
      step(0, 4'd3,  8'h8A, 8'h00); check("op3_sm2u2",    8'hF6, 4'b0010);
      step(0, 4'd3,  8'h80, 8'h00); check("op3_negzero",  8'h00, 4'b0001);
      step(0, 4'd7,  8'hF9, 8'h00); check("op7_u22sm",    8'h87, 4'b0010);
      step(0, 4'd7,  8'h80, 8'h00); check("op7_err",      8'h00, 4'b1000);
      step(0, 4'd4,  8'h03, 8'h01); check("op4_sub2b",    8'h01, 4'b0000);
      step(0, 4'd5,  8'h06, 8'h03); check("op5_lt",       8'h00, 4'b0001);
      step(0, 4'd6,  8'h03, 8'h02); check("op6_bit",      8'h01, 4'b0000);
      step(0, 4'd6,  8'h03, 8'h08); check("op6_err",      8'h00, 4'b1000);
      step(0, 4'd9,  8'hFC, 8'h01); check("op9_na_ge",    8'h01, 4'b0000);
      step(0, 4'd8,  8'hFC, 8'h0C); check("op8_na_shr",   8'h00, 4'b0001);
      step(0, 4'd11, 8'h00, 8'h55); check("op11_nabs",    8'hAA, 4'b0010);
      step(0, 4'd11, 8'h00, 8'h80); check("op11_err",     8'h00, 4'b1000);
      step(0, 4'd12, 8'h12, 8'h34); check("op12_err",     8'h00, 4'b1000);

      step(1, 4'd1,  8'h02, 8'hFC); check("reset_prio",   8'h00, 4'b0000);
      step(0, 4'd1,  8'h02, 8'hFC); check("reset_release", 8'h05, 4'b0000);

      for (int i = 0; i < 400; i++) begin
         op  = $urandom_range(0, 15);
         ua  = ($urandom_range(0, 7) == 0) ? 128 : $urandom_range(0, 255);
         ub  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 255);
         if (op == 0 && $urandom_range(0, 1) == 0) ub = 255 - $urandom_range(0, 9);
         rst = ($urandom_range(0, 19) == 0);
         step(rst, op[3:0], ua[7:0], ub[7:0]);
         exp = rst ? 12'h000 : model(op, ua, ub);
         check($sformatf("rand%0d_op%0d_a%02h_b%02h", i, op, ua, ub), exp[7:0], exp[11:8]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
